burst_line_fill_m: RTL and testbench
====================================

BURST_LINE_FILL_M -- requirements
Module: burst_line_fill_m

Interface
REQ-001 Parameter I_BURST, 3'h4, beats per line fill; legal values 1..7.
REQ-002 Parameter I_CACHE_LENGTH, I_BURST*32, width in bits of the assembled line.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 av_address  input  32  line-fill byte address from the cache.
REQ-006 av_read  input  1  fill request from the cache.
REQ-007 av_burstcount  input  3  requested beats; sampled and ignored (I_BURST is used).
REQ-008 av_wait_data  output  1  high while a fill is pending.
REQ-009 av_reddata  output  I_CACHE_LENGTH  assembled line.
REQ-010 m_address  output  32  Avalon-MM burst start address.
REQ-011 m_read  output  1  Avalon-MM read command.
REQ-012 m_burstcount  output  3  Avalon-MM burst length; always I_BURST.
REQ-013 m_waitrequest  input  1  slave stall of the command phase.
REQ-014 m_readdata  input  32  returned beat.
REQ-015 m_readdatavalid  input  1  beat qualifier.

Function
REQ-016 States: IDLE, REQ, COLLECT, DONE; the state register is updated on the rising edge of clk.
REQ-017 IDLE: when av_read=1, latch {av_address[31:4],4'h0} into m_address, clear the beat counter, and go to REQ on the next edge.
REQ-018 IDLE with av_read=0: hold the state and keep m_read=0.
REQ-019 REQ: m_read=1, registered, asserted from the cycle after acceptance; m_address and m_burstcount are held stable.
REQ-020 REQ: if m_read=1 and m_waitrequest=0, go to COLLECT and deassert m_read on the next edge.
REQ-021 REQ: if m_waitrequest=1, stay in REQ indefinitely with m_read held at 1.
REQ-022 In REQ or COLLECT, each m_readdatavalid=1 writes m_readdata into line buffer bits [32k+31:32k], where k is the beat counter, then increments k.
REQ-023 A beat arriving in REQ in the same cycle as command acceptance is captured.
REQ-024 When the beat with k=I_BURST-1 is captured, copy the full line buffer into av_reddata on the same edge and go to DONE.
REQ-025 DONE lasts exactly one cycle, then goes to IDLE; av_read is ignored during DONE.
REQ-026 av_wait_data = 1 in REQ and COLLECT; = av_read in IDLE (combinational); = 0 in DONE.
REQ-027 av_reddata changes only on the completing edge and otherwise holds the last completed line.
REQ-028 m_readdatavalid in IDLE or DONE (stray or excess beats) is ignored and does not change the buffer or the counter.
REQ-029 av_read held high or pulsed during REQ/COLLECT is ignored, with no second request queued; a held av_read after DONE starts a new fill.
REQ-030 Latency with zero wait states: av_read=1 at edge 0, m_read=1 after edge 1, command accepted at edge 2, beats at edges 3..(2+I_BURST), av_wait_data=0 in the cycle after the final-beat edge.
REQ-031 The beat counter is 3 bits wide and never wraps within a fill, since the fill terminates at I_BURST-1.

Reset
REQ-032 resetn=0 forces the following asynchronously: state=IDLE, m_read=0, m_address=0, beat counter=0, line buffer=0, av_reddata=0.
REQ-033 During reset, av_wait_data follows REQ-026 (IDLE rule); m_burstcount stays constant at I_BURST.
REQ-034 Reset mid-burst abandons the fill; beats still arriving after deassertion are dropped per REQ-028.

Verification
REQ-035 Zero-wait fill: av_address=0x0000_1234, av_read pulse; slave returns 0x11111111..0x44444444 -> m_address=0x0000_1230, m_burstcount=4, av_reddata=0x44444444_33333333_22222222_11111111, av_wait_data low at edge 7.
REQ-036 Command stall: m_waitrequest=1 for 5 cycles -> m_read stays 1 with a constant address for all 5 cycles, and exactly one command is accepted.
REQ-037 Gapped beats: m_readdatavalid pattern 1,0,0,1,0,1,1 -> beats land in order 0..3, and DONE occurs only after the 4th valid beat.
REQ-038 Back-to-back: av_read held high across DONE -> the second fill starts in the cycle after DONE, and the first line stays on av_reddata until the second completes.
REQ-039 Reset after 2 beats -> all outputs return to reset values immediately; the remaining 2 beats are ignored; a following fill completes correctly.
REQ-040 Stray m_readdatavalid in IDLE with data 0xDEADBEEF -> av_reddata and the beat counter are unchanged.

Source files
------------

// File: rtl/burst_line_fill_m_if.sv
// Avalon-MM burst read bus between the line-fill engine (master) and memory (slave).
interface burst_line_fill_m_if;
    logic [31:0] m_address;
    logic        m_read;
    logic [2:0]  m_burstcount;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;

    modport master (
        output m_address, m_read, m_burstcount,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    modport slave (
        input  m_address, m_read, m_burstcount,
        output m_waitrequest, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/burst_line_fill_m.sv
// Cache line-fill engine: turns one cache fill request into a fixed-length
// Avalon-MM burst read and assembles the returned beats into a full line.
module burst_line_fill_m #(
    parameter logic [2:0] I_BURST        = 3'h4,
    parameter int         I_CACHE_LENGTH = I_BURST * 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [31:0]               av_address,
    input  logic                      av_read,
    input  logic [2:0]                av_burstcount,
    output logic                      av_wait_data,
    output logic [I_CACHE_LENGTH-1:0] av_reddata,
    burst_line_fill_m_if.master       m_bus
);
    typedef enum logic [1:0] {IDLE, REQ, COLLECT, DONE} state_t;

    localparam logic [2:0] LAST = I_BURST - 3'd1;

    state_t                   state;
    logic [2:0]               beat;
    logic [I_BURST-1:0][31:0] line_buf;
    logic [I_BURST-1:0][31:0] line_next;
    logic                     capture;
    logic                     unused_burstcount;

    // The cache's requested length is irrelevant; the burst is always I_BURST.
    assign unused_burstcount   = ^av_burstcount;
    assign m_bus.m_burstcount  = I_BURST;

    // Beats are only meaningful while a fill is outstanding.
    assign capture = m_bus.m_readdatavalid && (state == REQ || state == COLLECT);

    always_comb begin
        line_next = line_buf;
        for (int i = 0; i < int'(I_BURST); i++)
            if (beat == 3'(i)) line_next[i] = m_bus.m_readdata;
    end

    always_comb begin
        case (state)
            IDLE:        av_wait_data = av_read;
            REQ,
            COLLECT:     av_wait_data = 1'b1;
            default:     av_wait_data = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            m_bus.m_read    <= 1'b0;
            m_bus.m_address <= '0;
            beat            <= '0;
            line_buf        <= '0;
            av_reddata      <= '0;
        end else begin
            case (state)
                IDLE: if (av_read) begin
                    m_bus.m_address <= {av_address[31:4], 4'h0};
                    beat            <= '0;
                    m_bus.m_read    <= 1'b1;
                    state           <= REQ;
                end
                REQ: if (m_bus.m_read && !m_bus.m_waitrequest) begin
                    m_bus.m_read <= 1'b0;
                    state        <= COLLECT;
                end
                COLLECT: ;
                DONE: state <= IDLE;
            endcase
            // Placed after the case so a completing beat overrides REQ->COLLECT.
            if (capture) begin
                line_buf <= line_next;
                beat     <= beat + 3'd1;
                if (beat == LAST) begin
                    av_reddata   <= line_next;
                    m_bus.m_read <= 1'b0;
                    state        <= DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_burst_line_fill_m.sv
// Randomized bench for burst_line_fill_m against a per-fill line model.
module tb_burst_line_fill_m;
    localparam logic [2:0] NB = 3'h4;
    localparam int         LW = 128;

    logic          clk = 1'b0;
    logic          resetn;
    logic [31:0]   av_address;
    logic          av_read;
    logic [2:0]    av_burstcount;
    logic          av_wait_data;
    logic [LW-1:0] av_reddata;

    burst_line_fill_m_if bus();

    burst_line_fill_m #(.I_BURST(NB), .I_CACHE_LENGTH(LW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .av_address    (av_address),
        .av_read       (av_read),
        .av_burstcount (av_burstcount),
        .av_wait_data  (av_wait_data),
        .av_reddata    (av_reddata),
        .m_bus         (bus.master)
    );

    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_pass = 0;
    int            acc_cnt = 0;
    int            lat;
    logic [LW-1:0] model_line = '0;

    // Count accepted commands as seen on the bus.
    always @(posedge clk)
        if (resetn && bus.m_read && !bus.m_waitrequest) acc_cnt++;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input bit v, input bit fixed, inout logic [31:0] beats[$]);
        logic [31:0] d;
        d = fixed ? 32'h11111111 * 32'(beats.size() + 1) : $urandom;
        bus.m_readdatavalid = v;
        bus.m_readdata      = d;
        if (v) beats.push_back(d);
    endtask

    // One complete fill; the model line is the beats in arrival order.
    task automatic fill(input logic [31:0] addr, input int stall, input logic [15:0] pat,
                        input bit use_pat, input bit fixed, input bit beat_at_acc,
                        input bit hold_after, output int ticks);
        logic [31:0]   beats[$];
        logic [LW-1:0] exp_line;
        int            a0, pi;
        bit            v;
        a0 = acc_cnt;
        av_address    = addr;
        av_read       = 1'b1;
        av_burstcount = 3'($urandom);
        #1 check("wait_idle_req", LW'(av_wait_data), LW'(1));
        tick(); ticks = 1;
        av_read = 1'b0;
        #1;
        check("cmd_read", LW'(bus.m_read), LW'(1));
        check("cmd_addr", LW'(bus.m_address), LW'(addr & 32'hFFFF_FFF0));
        check("cmd_bcnt", LW'(bus.m_burstcount), LW'(NB));
        bus.m_waitrequest = 1'b1;
        for (int s = 0; s < stall; s++) begin
            tick(); ticks++;
            check("stall_read", LW'(bus.m_read), LW'(1));
            check("stall_addr", LW'(bus.m_address), LW'(addr & 32'hFFFF_FFF0));
        end
        bus.m_waitrequest = 1'b0;
        drive_beat(beat_at_acc, fixed, beats);
        tick(); ticks++;
        bus.m_readdatavalid = 1'b0;
        check("accept_drop", LW'(bus.m_read), LW'(0));
        pi = 0;
        while (beats.size() < int'(NB)) begin
            v = use_pat ? pat[pi[3:0]] : ($urandom_range(0, 2) != 0);
            if (pi >= 40) v = 1'b1;
            pi++;
            av_read = ($urandom_range(0, 3) == 0);
            drive_beat(v, fixed, beats);
            tick(); ticks++;
            if (beats.size() < int'(NB)) begin
                check("line_hold", av_reddata, model_line);
                check("wait_busy", LW'(av_wait_data), LW'(1));
            end
        end
        bus.m_readdatavalid = 1'b0;
        av_read = hold_after;
        exp_line = '0;
        for (int k = 0; k < int'(NB); k++) exp_line[32*k +: 32] = beats[k];
        model_line = exp_line;
        #1;
        check("line", av_reddata, model_line);
        check("done_wait", LW'(av_wait_data), LW'(0));
        check("one_cmd", LW'(acc_cnt - a0), LW'(1));
        // Excess beat during DONE must not disturb anything.
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'hDEADBEEF;
        tick();
        bus.m_readdatavalid = 1'b0;
        #1;
        check("stray_done", av_reddata, model_line);
        check("idle_wait", LW'(av_wait_data), LW'(hold_after));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        av_address = '0; av_read = 1'b0; av_burstcount = '0;
        bus.m_waitrequest = 1'b0; bus.m_readdata = '0; bus.m_readdatavalid = 1'b0;
        tick(); tick();
        check("rst_read", LW'(bus.m_read), LW'(0));
        check("rst_addr", LW'(bus.m_address), LW'(0));
        check("rst_line", av_reddata, '0);
        check("rst_bcnt", LW'(bus.m_burstcount), LW'(NB));
        check("rst_wait", LW'(av_wait_data), LW'(0));
        resetn = 1'b1;
        tick();

        // Zero-wait fill with known data and latency.
        fill(32'h0000_1234, 0, 16'h000F, 1'b1, 1'b1, 1'b0, 1'b0, lat);
        check("latency", LW'(lat), LW'(6));
        check("known_line", av_reddata, 128'h44444444_33333333_22222222_11111111);

        // Command stall, then gapped beats.
        fill($urandom, 5, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        fill($urandom, 0, 16'h0069, 1'b1, 1'b0, 1'b0, 1'b0, lat);

        // Back-to-back with av_read held across DONE.
        fill($urandom, 1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, lat);
        fill($urandom, 0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, lat);

        // Stray beat in IDLE; the next fill proves the counter was untouched.
        bus.m_readdatavalid = 1'b1; bus.m_readdata = 32'hDEADBEEF;
        tick();
        bus.m_readdatavalid = 1'b0;
        check("stray_idle", av_reddata, model_line);
        fill($urandom, 0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, lat);

        // Reset after two beats.
        av_address = $urandom; av_read = 1'b1;
        tick();
        av_read = 1'b0;
        tick();
        bus.m_readdatavalid = 1'b1; bus.m_readdata = $urandom;
        tick(); tick();
        resetn = 1'b0;
        #1;
        check("mid_rst_read", LW'(bus.m_read), LW'(0));
        check("mid_rst_addr", LW'(bus.m_address), LW'(0));
        check("mid_rst_line", av_reddata, '0);
        check("mid_rst_wait", LW'(av_wait_data), LW'(0));
        av_read = 1'b1;
        #1 check("rst_wait_follow", LW'(av_wait_data), LW'(1));
        av_read = 1'b0;
        tick();
        resetn = 1'b1;
        tick(); tick();
        bus.m_readdatavalid = 1'b0;
        model_line = '0;
        check("post_rst_line", av_reddata, model_line);
        check("post_rst_wait", LW'(av_wait_data), LW'(0));
        fill($urandom, 2, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, lat);

        // Randomized fills.
        for (int n = 0; n < 20; n++)
            fill($urandom, $urandom_range(0, 3), 16'h0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                 (n < 19) ? 1'($urandom_range(0, 1)) : 1'b0, lat);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
